// File: rtl/mips_bus_pkg.sv
// Shared bus types for mips_cpu_bus and mips_bus_ram: reset vector, handshake FSM
// states and the word/byte-enable types.
package mips_bus_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

    typedef enum logic {IDLE, WAIT} bus_state_t;

    typedef logic [3:0]  byteen_t;
    typedef logic [31:0] word_t;

endpackage

// File: rtl/mips_bus_ram_if.sv
// Avalon-MM-style memory bus between the CPU (master) and mips_bus_ram (slave).
interface mips_bus_ram_if;
    import mips_bus_pkg::*;

    word_t   address;
    logic    read;
    logic    write;
    byteen_t byteenable;
    word_t   writedata;
    logic    waitrequest;
    word_t   readdata;
    logic    bus_error;

    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata, bus_error
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata, bus_error
    );

endinterface

// File: rtl/mips_bus_ram_decode.sv
// Address decode for mips_bus_ram: maps a byte address onto the combined
// low-memory + boot-region word array.
module mips_bus_ram_decode
    import mips_bus_pkg::*;
#(
    parameter int unsigned LOW_WORDS    = 256,
    parameter int unsigned BOOT_WORDS   = 256,
    parameter word_t       RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int unsigned IDX_W        = 9
) (
    input  word_t             addr_i,
    output logic              hit_o,
    output logic              aligned_o,
    output logic [IDX_W-1:0]  index_o
);

    word_t boot_off;
    logic  low_hit;
    logic  boot_hit;

    always_comb begin
        boot_off  = addr_i - RESET_VECTOR;
        low_hit   = addr_i < word_t'(LOW_WORDS * 4);
        // Lower bound check keeps addresses below the vector from wrapping into the region
        boot_hit  = (addr_i >= RESET_VECTOR) && (boot_off < word_t'(BOOT_WORDS * 4));
        hit_o     = low_hit | boot_hit;
        aligned_o = (addr_i[1:0] == 2'b00);
        if (low_hit) index_o = IDX_W'(addr_i >> 2);
        else         index_o = IDX_W'(word_t'(LOW_WORDS) + (boot_off >> 2));
    end

endmodule

// File: rtl/mips_bus_ram.sv
// Wait-stated byte-lane memory slave for mips_cpu_bus.
// Define MIPS_BUS_RAM_RANDOM_WAIT_EN for LFSR-driven per-transaction wait states.
module mips_bus_ram
  import mips_bus_pkg::*;
#(
  parameter int unsigned LOW_WORDS    = 256,
  parameter int unsigned BOOT_WORDS   = 256,
  parameter word_t       RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int unsigned WAIT_CYCLES  = 0,
  parameter              INIT_FILE    = ""
) (
  input  logic            clk,
  input  logic            reset,
  mips_bus_ram_if.slave   bus
);

  localparam int unsigned WORDS = LOW_WORDS + BOOT_WORDS;
  localparam int unsigned IDX_W = $clog2(WORDS);

  word_t      mem_q [WORDS];
  bus_state_t state_q;
  logic [3:0] cnt_q;
  word_t      rdata_q;
  word_t      rdata_d;
  logic       err_q;

  logic             req;
  logic             waitreq;
  logic             accept;
  logic             err_cond;
  logic             hit;
  logic             aligned;
  logic [IDX_W-1:0] idx;
  logic [3:0]       wait_n;
  word_t            lane_mask;

  mips_bus_ram_decode #(
    .LOW_WORDS    (LOW_WORDS),
    .BOOT_WORDS   (BOOT_WORDS),
    .RESET_VECTOR (RESET_VECTOR),
    .IDX_W        (IDX_W)
  ) u_decode (
    .addr_i    (bus.address),
    .hit_o     (hit),
    .aligned_o (aligned),
    .index_o   (idx)
  );

`ifdef MIPS_BUS_RAM_RANDOM_WAIT_EN
  logic [7:0] lfsr_q;

  assign wait_n = {2'b00, lfsr_q[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       lfsr_q <= 8'hA5;
    else if (accept) lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end
`else
  assign wait_n = 4'(WAIT_CYCLES);
`endif

  always_comb begin
    req      = bus.read | bus.write;
    waitreq  = req & (((state_q == IDLE) && (wait_n != 4'd0)) ||
                      ((state_q == WAIT) && (cnt_q != 4'd0)));
    accept   = req & ~waitreq;
    err_cond = ~hit | ~aligned | (bus.read & bus.write);
    for (int unsigned i = 0; i < 4; i++) lane_mask[8*i +: 8] = {8{bus.byteenable[i]}};
    rdata_d  = '0;
    if (hit && !err_cond) rdata_d = mem_q[idx] & lane_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req && wait_n != 4'd0) begin
          state_q <= WAIT;
          cnt_q   <= wait_n - 4'd1;
        end
        WAIT: if (!req) begin
          state_q <= IDLE;
          err_q   <= 1'b1;
        end else if (cnt_q == 4'd0) begin
          state_q <= IDLE;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
      if (accept) begin
        if (err_cond) err_q <= 1'b1;
        // A simultaneous read+write is an error that leaves readdata alone
        if (bus.read && !bus.write) rdata_q <= rdata_d;
      end
    end
  end

  // Array is never reset; the reset gate stops a held request from landing during reset.
  always_ff @(posedge clk) begin
    if (accept && bus.write && !err_cond && !reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (bus.byteenable[i]) mem_q[idx][8*i +: 8] <= bus.writedata[8*i +: 8];
      end
    end
  end

  assign bus.waitrequest = waitreq;
  assign bus.readdata    = rdata_q;
  assign bus.bus_error   = err_q;

endmodule

// File: tb/tb_mips_bus_ram.sv
// Directed bench for mips_bus_ram: a zero-wait and a three-wait instance share one
// stimulus stream, steered to one instance at a time.
module tb_mips_bus_ram;
    import mips_bus_pkg::*;

    logic    clk = 1'b0;
    logic    reset = 1'b1;
    logic    sel = 1'b0;
    logic    rd = 1'b0;
    logic    wr = 1'b0;
    word_t   addr = '0;
    byteen_t be = '0;
    word_t   wd = '0;

    int n_vec = 0;
    int n_miss = 0;

    mips_bus_ram_if if0 ();
    mips_bus_ram_if if3 ();

    assign if0.address    = addr;
    assign if0.read       = rd & ~sel;
    assign if0.write      = wr & ~sel;
    assign if0.byteenable = be;
    assign if0.writedata  = wd;
    assign if3.address    = addr;
    assign if3.read       = rd & sel;
    assign if3.write      = wr & sel;
    assign if3.byteenable = be;
    assign if3.writedata  = wd;

    mips_bus_ram #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
    mips_bus_ram #(.WAIT_CYCLES(3)) dut3 (.clk(clk), .reset(reset), .bus(if3.slave));

    always #5 clk = ~clk;

`ifdef MIPS_BUS_RAM_RANDOM_WAIT_EN
    logic [7:0] mlfsr [2];
    function automatic int exp_wait(input bit s);
        return int'(mlfsr[s][1:0]);
    endfunction
    task automatic model_adv(input bit s);
        mlfsr[s] = {mlfsr[s][6:0], mlfsr[s][7] ^ mlfsr[s][5] ^ mlfsr[s][4] ^ mlfsr[s][3]};
    endtask
    task automatic model_rst();
        mlfsr[0] = 8'hA5;
        mlfsr[1] = 8'hA5;
    endtask
`else
    function automatic int exp_wait(input bit s);
        return s ? 3 : 0;
    endfunction
    task automatic model_adv(input bit s);
        if (s) ;
    endtask
    task automatic model_rst();
    endtask
`endif

    function automatic logic cur_wreq(input bit s);
        return s ? if3.waitrequest : if0.waitrequest;
    endfunction
    function automatic word_t cur_rdata(input bit s);
        return s ? if3.readdata : if0.readdata;
    endfunction

    task automatic chk(input string tag, input word_t got, input word_t exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One request held until accepted (bounded at 40 waits).
    task automatic xfer(input bit s, input bit r, input bit w, input word_t a,
                        input byteen_t b, input word_t d, output int waits);
        @(negedge clk);
        sel = s; rd = r; wr = w; addr = a; be = b; wd = d;
        waits = 0;
        #1;
        while (cur_wreq(s) && waits < 40) begin
            @(negedge clk);
            #1;
            waits++;
        end
        @(posedge clk);
        #1;
        rd = 1'b0;
        wr = 1'b0;
        if (waits < 40) model_adv(s);
    endtask

    task automatic wr_do(input string tag, input bit s, input word_t a, input byteen_t b, input word_t d);
        int wt;
        int ew;
        ew = exp_wait(s);
        xfer(s, 1'b0, 1'b1, a, b, d, wt);
        chk({tag, "_wait"}, word_t'(wt), word_t'(ew));
    endtask

    task automatic rd_chk(input string tag, input bit s, input word_t a, input byteen_t b, input word_t exp);
        int wt;
        int ew;
        ew = exp_wait(s);
        xfer(s, 1'b1, 1'b0, a, b, '0, wt);
        chk({tag, "_wait"}, word_t'(wt), word_t'(ew));
        chk(tag, cur_rdata(s), exp);
    endtask

    initial begin
        int wt;
        model_rst();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_rdata0", if0.readdata, '0);
        chk("rst_err0",   word_t'(if0.bus_error), '0);
        chk("rst_rdata3", if3.readdata, '0);
        chk("rst_err3",   word_t'(if3.bus_error), '0);

        // Zero-wait instance: full words, lanes, region boundaries
        wr_do ("w4",      1'b0, 32'h4, 4'hF, 32'h5C3AF8FC);
        rd_chk("lw4",     1'b0, 32'h4, 4'hF, 32'h5C3AF8FC);
        wr_do ("w8",      1'b0, 32'h8, 4'hF, 32'h2EAC0652);
        wr_do ("w8_be5",  1'b0, 32'h8, 4'h5, 32'hDEADBEEF);
        rd_chk("lw8",     1'b0, 32'h8, 4'hF, 32'h2EAD06EF);
        rd_chk("lh8",     1'b0, 32'h8, 4'h3, 32'h000006EF);
        wr_do ("w8_be0",  1'b0, 32'h8, 4'h0, 32'hFFFFFFFF);
        rd_chk("lw8_be0", 1'b0, 32'h8, 4'hF, 32'h2EAD06EF);
        wr_do ("wlast",   1'b0, 32'h3FC, 4'hF, 32'h0BAD0FF1);
        rd_chk("lwlast",  1'b0, 32'h3FC, 4'hF, 32'h0BAD0FF1);
        wr_do ("wboot",   1'b0, 32'hBFC00000, 4'hF, 32'h01010101);
        wr_do ("wbtop",   1'b0, 32'hBFC003FC, 4'hF, 32'h11223344);
        rd_chk("lwbtop",  1'b0, 32'hBFC003FC, 4'hF, 32'h11223344);
        chk("err0_clean", word_t'(if0.bus_error), '0);

        // Errors: misaligned, misses, read+write together
        rd_chk("lw4b",    1'b0, 32'h4, 4'hF, 32'h5C3AF8FC);
        rd_chk("misal",   1'b0, 32'h402, 4'hF, 32'h0);
        chk("misal_err",  word_t'(if0.bus_error), 32'h1);
        rd_chk("after_err", 1'b0, 32'h8, 4'hF, 32'h2EAD06EF);
        chk("err_sticky", word_t'(if0.bus_error), 32'h1);
        wr_do ("wmiss",   1'b0, 32'h400, 4'hF, 32'h99999999);
        rd_chk("noalias", 1'b0, 32'hBFC00000, 4'hF, 32'h01010101);
        rd_chk("lw8c",    1'b0, 32'h8, 4'hF, 32'h2EAD06EF);
        xfer(1'b0, 1'b1, 1'b1, 32'h8, 4'hF, 32'hAAAAAAAA, wt);
        chk("rw_keep",    if0.readdata, 32'h2EAD06EF);
        rd_chk("rw_nowr", 1'b0, 32'h8, 4'hF, 32'h2EAD06EF);
        rd_chk("bootend", 1'b0, 32'hBFC00400, 4'hF, 32'h0);

        // Three-wait instance
        chk("err3_clean", word_t'(if3.bus_error), '0);
        wr_do ("w3boot",  1'b1, 32'hBFC00000, 4'hF, 32'hA0B1C2D3);
        rd_chk("lw3boot", 1'b1, 32'hBFC00000, 4'hF, 32'hA0B1C2D3);
        wr_do ("w3zero",  1'b1, 32'h0, 4'hF, 32'hCAFEF00D);
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) rd_chk("b2b_boot", 1'b1, 32'hBFC00000, 4'hF, 32'hA0B1C2D3);
            else            rd_chk("b2b_zero", 1'b1, 32'h0, 4'hF, 32'hCAFEF00D);
        end
        chk("err3_b2b", word_t'(if3.bus_error), '0);

`ifndef MIPS_BUS_RAM_RANDOM_WAIT_EN
        // Request withdrawn while waiting
        @(negedge clk);
        sel = 1'b1; rd = 1'b1; addr = 32'hBFC00000; be = 4'hF;
        @(negedge clk);
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
        #1;
        chk("drop_err",   word_t'(if3.bus_error), 32'h1);
        chk("drop_wreq",  word_t'(if3.waitrequest), '0);
        chk("drop_rdata", if3.readdata, 32'hCAFEF00D);

        // Reset lands while a write is still waiting
        @(negedge clk);
        sel = 1'b1; wr = 1'b1; addr = 32'h0; be = 4'hF; wd = 32'h12345678;
        @(negedge clk);
        #1;
        reset = 1'b1;
        wr = 1'b0;
        #1;
        chk("rstw_wreq",  word_t'(if3.waitrequest), '0);
        chk("rstw_err3",  word_t'(if3.bus_error), '0);
        chk("rstw_err0",  word_t'(if0.bus_error), '0);
        chk("rstw_rdata", if3.readdata, '0);
        @(negedge clk);
        reset = 1'b0;
        model_rst();
        rd_chk("rstw_word0", 1'b1, 32'h0, 4'hF, 32'hCAFEF00D);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
